// File: rtl/config_frame_fsm.sv
// Configuration frame parser: locks onto a sync word, decodes frame headers and
// steers the following row-data words into one-hot row write enables with a commit strobe.
module config_frame_fsm #(
  parameter int unsigned NUM_ROWS   = 16,
  parameter int unsigned MAX_FRAMES = 20,
  parameter logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         word_in,
  input  logic                word_valid,
  input  logic                link_active,
  output logic [31:0]         row_data,
  output logic [NUM_ROWS-1:0] row_we,
  output logic [6:0]          col_sel,
  output logic [7:0]          frame_sel,
  output logic                frame_strobe,
  output logic                busy,
  output logic                error,
  output logic [15:0]         frames_done
);

  localparam int unsigned         CW          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [7:0]          FRAME_LIMIT = 8'(MAX_FRAMES);
  localparam logic [15:0]         CNT_LIMIT   = 16'(NUM_ROWS);
  localparam logic [NUM_ROWS-1:0] ROW0        = NUM_ROWS'(1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, COMMIT} state_t;

  state_t        state;
  logic [CW-1:0] row_ctr;
  logic [15:0]   words_left;

  logic        hdr_desync;
  logic [6:0]  hdr_col;
  logic [7:0]  hdr_frame;
  logic [15:0] hdr_cnt;
  logic        hdr_bad;

  assign hdr_desync = word_in[31];
  assign hdr_col    = word_in[30:24];
  assign hdr_frame  = word_in[23:16];
  assign hdr_cnt    = word_in[15:0];
  assign hdr_bad    = (hdr_frame >= FRAME_LIMIT) || (hdr_cnt == '0) || (hdr_cnt > CNT_LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      row_ctr      <= '0;
      words_left   <= '0;
      row_data     <= '0;
      row_we       <= '0;
      col_sel      <= '0;
      frame_sel    <= '0;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      frames_done  <= '0;
    end else begin
      row_we       <= '0;
      frame_strobe <= 1'b0;
      if (state != IDLE && !link_active) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (word_valid && word_in == SYNC_WORD) begin
              state <= HEADER;
              busy  <= 1'b1;
              error <= 1'b0;
            end
          end
          DATA: begin
            if (word_valid) begin
              row_data   <= word_in;
              row_we     <= ROW0 << row_ctr;
              row_ctr    <= row_ctr + 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= COMMIT;
            end
          end
          COMMIT: begin
            frame_strobe <= 1'b1;
            if (frames_done != '1) frames_done <= frames_done + 16'd1;
            state <= HEADER;
          end
          default: ;
        endcase
        // The commit cycle also decodes headers so a word arriving there is not lost;
        // this block overrides the COMMIT -> HEADER default above.
        if ((state == HEADER || state == COMMIT) && word_valid) begin
          if (hdr_desync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hdr_bad) begin
            error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            col_sel    <= hdr_col;
            frame_sel  <= hdr_frame;
            row_ctr    <= '0;
            words_left <= hdr_cnt;
            state      <= DATA;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_config_frame_fsm.sv
// Scenario bench for config_frame_fsm: expected row writes and commit strobes are queued
// with their due cycle as words are driven, and a negedge monitor retires them.
module tb_config_frame_fsm;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        link_active = 1'b1;
  logic [31:0] row_data;
  logic [15:0] row_we;
  logic [6:0]  col_sel;
  logic [7:0]  frame_sel;
  logic        frame_strobe;
  logic        busy;
  logic        error;
  logic [15:0] frames_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_frames = 0;

  typedef struct {
    int          cyc;
    logic [15:0] we;
    logic [31:0] data;
  } row_exp_t;

  row_exp_t rq[$];
  int       sq[$];
  row_exp_t mon_e;
  int       mon_s;

  config_frame_fsm #(.NUM_ROWS(16), .MAX_FRAMES(20), .SYNC_WORD(SYNC)) dut (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_valid(word_valid),
    .link_active(link_active), .row_data(row_data), .row_we(row_we),
    .col_sel(col_sel), .frame_sel(frame_sel), .frame_strobe(frame_strobe),
    .busy(busy), .error(error), .frames_done(frames_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (row_we !== '0) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL row_unexpected: row_we=%h row_data=%h at cycle %0d, expected no write", row_we, row_data, cyc);
        end else begin
          mon_e = rq.pop_front();
          if (row_we !== mon_e.we || row_data !== mon_e.data || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL row_write: got we=%h data=%h cycle=%0d, expected we=%h data=%h cycle=%0d",
                     row_we, row_data, cyc, mon_e.we, mon_e.data, mon_e.cyc);
          end
        end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        mon_e = rq.pop_front();
        checks++;
        errors++;
        $display("FAIL row_missing: no write by cycle %0d, expected we=%h data=%h at cycle %0d", cyc, mon_e.we, mon_e.data, mon_e.cyc);
      end
      if (frame_strobe !== 1'b0) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: frame_strobe=%b at cycle %0d, expected none", frame_strobe, cyc);
        end else begin
          mon_s = sq.pop_front();
          if (cyc != mon_s || frame_strobe !== 1'b1) begin
            errors++;
            $display("FAIL strobe_timing: strobe=%b at cycle %0d, expected 1 at cycle %0d", frame_strobe, cyc, mon_s);
          end
        end
      end
      while (sq.size() > 0 && sq[0] < cyc) begin
        mon_s = sq.pop_front();
        checks++;
        errors++;
        $display("FAIL strobe_missing: none by cycle %0d, expected at cycle %0d", cyc, mon_s);
      end
    end
  end

  function automatic logic [31:0] hdr(input logic ds, input logic [6:0] col,
                                      input logic [7:0] frm, input logic [15:0] cnt);
    return {ds, col, frm, cnt};
  endfunction

  task automatic drive_word(input logic [31:0] w, input bit exp_row,
                            input logic [15:0] we, input bit exp_strobe);
    row_exp_t t;
    @(negedge clk);
    word_in = w;
    word_valid = 1'b1;
    if (exp_row) begin
      t.cyc = cyc + 1;
      t.we = we;
      t.data = w;
      rq.push_back(t);
    end
    if (exp_strobe) sq.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      word_valid = 1'b0;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    word_valid = 1'b0;
    link_active = 1'b0;
    @(negedge clk);
    link_active = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({row_data, row_we, col_sel, frame_sel, frame_strobe, busy, error, frames_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h we=%h col=%h frm=%h strb=%b busy=%b err=%b done=%h, expected all 0",
               row_data, row_we, col_sel, frame_sel, frame_strobe, busy, error, frames_done);
    end
    resetn = 1'b1;
    idle(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
  endtask

  task automatic test_basic_frame();
    go_idle();
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd3, 8'd5, 16'd2), 0, '0, 0);
    drive_word(32'hAAAA_0001, 1, 16'h0001, 0);
    drive_word(32'hBBBB_0002, 1, 16'h0002, 1);
    exp_frames++;
    idle(4);
    checks++;
    if (frames_done !== 16'(exp_frames)) begin errors++; $display("FAIL basic_frames_done: got %0d expected %0d", frames_done, exp_frames); end
    checks++;
    if (col_sel !== 7'd3 || frame_sel !== 8'd5) begin errors++; $display("FAIL basic_sel: col=%0d frm=%0d expected col=3 frm=5", col_sel, frame_sel); end
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_state: busy=%b err=%b expected busy=1 err=0", busy, error); end
  endtask

  task automatic test_full_frame();
    go_idle();
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd10, 8'd0, 16'd16), 0, '0, 0);
    for (int i = 0; i < 16; i++) begin
      drive_word(32'h1000_0000 + 32'(i) * 32'h0101_0101, 1, 16'(1) << i, i == 15);
    end
    exp_frames++;
    idle(4);
    checks++;
    if (frames_done !== 16'(exp_frames)) begin errors++; $display("FAIL full_frames_done: got %0d expected %0d", frames_done, exp_frames); end
    checks++;
    if (col_sel !== 7'd10 || frame_sel !== 8'd0) begin errors++; $display("FAIL full_sel: col=%0d frm=%0d expected col=10 frm=0", col_sel, frame_sel); end
  endtask

  task automatic test_header_errors();
    logic [31:0] bad[3];
    bad[0] = hdr(1'b0, 7'd1, 8'd20, 16'd1);
    bad[1] = hdr(1'b0, 7'd1, 8'd2, 16'd0);
    bad[2] = hdr(1'b0, 7'd1, 8'd2, 16'd17);
    go_idle();
    for (int i = 0; i < 3; i++) begin
      drive_word(SYNC, 0, '0, 0);
      idle(1);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL err_sync_clear[%0d]: err=%b busy=%b expected err=0 busy=1", i, error, busy); end
      drive_word(bad[i], 0, '0, 0);
      drive_word(32'hDEAD_0000, 0, '0, 0);
      idle(2);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_header[%0d]: err=%b busy=%b expected err=1 busy=0", i, error, busy); end
      checks++;
      if (col_sel !== 7'd10 || frame_sel !== 8'd0) begin errors++; $display("FAIL err_sel_held[%0d]: col=%0d frm=%0d expected col=10 frm=0", i, col_sel, frame_sel); end
    end
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd7, 8'd19, 16'd1), 0, '0, 0);
    drive_word(32'h0000_1919, 1, 16'h0001, 1);
    exp_frames++;
    idle(3);
    checks++;
    if (error !== 1'b0 || frame_sel !== 8'd19 || col_sel !== 7'd7) begin
      errors++;
      $display("FAIL err_boundary_ok: err=%b col=%0d frm=%0d expected err=0 col=7 frm=19", error, col_sel, frame_sel);
    end
    checks++;
    if (frames_done !== 16'(exp_frames)) begin errors++; $display("FAIL err_frames_done: got %0d expected %0d", frames_done, exp_frames); end
  endtask

  task automatic test_link_abort();
    go_idle();
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd1, 8'd2, 16'd4), 0, '0, 0);
    drive_word(32'h0000_00A1, 1, 16'h0001, 0);
    drive_word(32'h0000_00A2, 1, 16'h0002, 0);
    go_idle();
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL abort_state: busy=%b err=%b expected busy=0 err=0", busy, error); end
    drive_word(32'h0000_00A3, 0, '0, 0);
    drive_word(SYNC + 32'd1, 0, '0, 0);
    idle(3);
    checks++;
    if (busy !== 1'b0 || frames_done !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL abort_ignored: busy=%b done=%0d expected busy=0 done=%0d", busy, frames_done, exp_frames);
    end
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd1, 8'd2, 16'd2), 0, '0, 0);
    drive_word(32'h0000_00B1, 1, 16'h0001, 0);
    @(negedge clk);
    word_in = 32'h0000_00B2;
    word_valid = 1'b1;
    link_active = 1'b0;
    @(negedge clk);
    word_valid = 1'b0;
    link_active = 1'b1;
    idle(3);
    checks++;
    if (busy !== 1'b0 || frames_done !== 16'(exp_frames) || error !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: busy=%b done=%0d err=%b expected busy=0 done=%0d err=0", busy, frames_done, error, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    go_idle();
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd4, 8'd8, 16'd1), 0, '0, 0);
    drive_word(32'hC0DE_0001, 1, 16'h0001, 1);
    drive_word(hdr(1'b0, 7'd5, 8'd9, 16'd2), 0, '0, 0);
    drive_word(32'hC0DE_0002, 1, 16'h0001, 0);
    drive_word(32'hC0DE_0003, 1, 16'h0002, 1);
    drive_word(hdr(1'b1, 7'd0, 8'd0, 16'd0), 0, '0, 0);
    exp_frames += 2;
    idle(4);
    checks++;
    if (frames_done !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frames_done: got %0d expected %0d", frames_done, exp_frames); end
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL b2b_desync: busy=%b err=%b expected busy=0 err=0", busy, error); end
    checks++;
    if (col_sel !== 7'd5 || frame_sel !== 8'd9) begin errors++; $display("FAIL b2b_sel: col=%0d frm=%0d expected col=5 frm=9", col_sel, frame_sel); end
  endtask

  task automatic test_reset_mid_frame();
    go_idle();
    drive_word(SYNC, 0, '0, 0);
    drive_word(hdr(1'b0, 7'd6, 8'd3, 16'd4), 0, '0, 0);
    drive_word(32'h5151_0001, 1, 16'h0001, 0);
    drive_word(32'h5151_0002, 1, 16'h0002, 0);
    @(negedge clk);
    word_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    exp_frames = 0;
    checks++;
    if ({row_data, row_we, col_sel, frame_sel, frame_strobe, busy, error, frames_done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h we=%h col=%h frm=%h strb=%b busy=%b err=%b done=%h, expected all 0",
               row_data, row_we, col_sel, frame_sel, frame_strobe, busy, error, frames_done);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive_word(32'h5151_0003, 0, '0, 0);
    idle(3);
    checks++;
    if (busy !== 1'b0 || frames_done !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL midreset_ignored: busy=%b done=%0d expected busy=0 done=0", busy, frames_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_full_frame();
    test_header_errors();
    test_link_abort();
    test_back_to_back();
    test_reset_mid_frame();
    idle(3);
    checks++;
    if (rq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d rows and %0d strobes outstanding, expected 0 and 0", rq.size(), sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
